// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: launch FSM encoding and default byte width.
package uart_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SETTLE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_BITS_DEFAULT,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a three-state launch FSM.
// Optional synchronous flush input when UART_TX_FIFO_FLUSH_EN is defined.
//
//   state  | meaning
//   IDLE   | wait for a queued byte and an idle transmitter
//   LAUNCH | tx_en high for one cycle, head byte popped at the end
//   SETTLE | one cycle covering the transmitter's registered busy latency
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  tx_state_t     state;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);
  assign level = level_q;
  assign tx_en = (state == LAUNCH);

`ifdef UART_TX_FIFO_FLUSH_EN
  // A write coinciding with flush is discarded silently, not counted as overflow.
  assign push = wr_en && !full && !flush;
  assign drop = wr_en && full && !flush;
`else
  assign push = wr_en && !full;
  assign drop = wr_en && full;
`endif
  assign pop = (state == LAUNCH) && !empty;

  uart_fifo_mem #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (tx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
`ifdef UART_TX_FIFO_FLUSH_EN
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else
`endif
      begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!empty && !tx_busy) state <= LAUNCH;
        LAUNCH:  state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
